// File: rtl/fir_ss_feeder.sv
// Sample buffer feeding the FIR core's AXI-Stream slave port: forwards a
// programmed number of samples through a small FWFT FIFO and flags the last beat.
module fir_ss_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst_n,
  input  logic [pLEN_WIDTH-1:0]    cfg_len,
  input  logic                     cfg_start,
  input  logic                     in_tvalid,
  input  logic [pDATA_WIDTH-1:0]   in_tdata,
  output logic                     in_tready,
  output logic                     ss_tvalid,
  output logic [pDATA_WIDTH-1:0]   ss_tdata,
  output logic                     ss_tlast,
  input  logic                     ss_tready,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [pLEN_WIDTH-1:0]    out_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                  state_q, state_d;
  logic [pDATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             level_q, level_d;
  logic [pLEN_WIDTH-1:0]   len_q, len_d;
  logic [pLEN_WIDTH-1:0]   in_count_q, in_count_d;
  logic [pLEN_WIDTH-1:0]   out_count_q, out_count_d;
  logic                    done_q, done_d;
  logic                    full, empty, push, pop;

  // Handshake outputs decode registered state only; no path from in_tvalid/ss_tready.
  always_comb begin
    full      = (level_q == (AW+1)'(DEPTH));
    empty     = (level_q == '0);
    in_tready = (state_q == RUN) && !full && (in_count_q < len_q);
    ss_tvalid = (state_q == RUN) && !empty;
    ss_tdata  = ss_tvalid ? mem[rd_ptr_q] : '0;
    ss_tlast  = ss_tvalid && (out_count_q == (len_q - pLEN_WIDTH'(1)));
    push      = in_tvalid && in_tready;
    pop       = ss_tvalid && ss_tready;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    len_d       = len_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    done_d      = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          in_count_d  = '0;
          out_count_d = '0;
          if (cfg_len != '0) begin
            len_d   = cfg_len;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (push) in_count_d  = in_count_q + pLEN_WIDTH'(1);
        if (pop)  out_count_d = out_count_q + pLEN_WIDTH'(1);
        if (pop && ss_tlast) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      len_q       <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      len_q       <= len_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr_q] <= in_tdata;
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign fifo_level = level_q;
  assign out_count  = out_count_q;

endmodule
